rf_wb_arbiter: RTL and testbench

Shares the register file's single write port between two write-back sources: the ALU result path and the late-returning memory-load path. It grants one write per cycle using round-robin fairness, drives registered write-enable, address and data into the register file, and suppresses writes to $zero. It also keeps a pending-load scoreboard that raises a read-hazard stall for the decode stage and blocks ALU writes that would overtake an outstanding load (WAW).

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 65 ++++++
 rtl/rf_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Width defaults live here so the scoreboard and the arbiter agree on them.
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 1 << RF_ADDR_W;

    localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

    // Identifies which write-back source won the most recent grant.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LD  = 1'b1
    } grant_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set at load issue and
// cleared at load write-back grant, plus read-hazard and WAW lookups.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] waw_addr,
    output logic              stall,
    output logic              waw_busy,
    output logic              issue_err
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                err_next;
    logic                set_live;
    logic                clr_same;

    assign set_live = set_en && (set_addr != ZERO);
    assign clr_same = clr_en && (clr_addr == set_addr);

    // Clear is applied before set so a same-cycle set of the same register
    // leaves it pending: the newly issued load is still outstanding.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_live) begin
            busy_next[set_addr] = 1'b1;
        end
    end

    assign err_next = issue_err | (set_live && busy[set_addr] && !clr_same);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= '0;
            issue_err <= 1'b0;
        end else begin
            busy      <= busy_next;
            issue_err <= err_next;
        end
    end

    // Lookups see the registered busy vector, so a clear in this cycle
    // only removes the stall from the following cycle onwards.
    assign stall = (busy[rd_addr1] && (rd_addr1 != ZERO))
                 | (busy[rd_addr2] && (rd_addr2 != ZERO));

    assign waw_busy = busy[waw_addr] && (waw_addr != ZERO);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load write-back paths, with registered write outputs and load scoreboard.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_addr,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              end_instr,
    output logic              ld_issue_err,
    output grant_t            last_grant
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    // Handshake: a write-back transfers in any cycle where valid and ready
    // are both high. ready is combinational from valid, the scoreboard and
    // last_grant; the requester keeps addr/data stable until it sees ready.

    logic              waw_busy;
    logic              alu_elig;
    logic              ld_elig;
    logic              alu_grant;
    logic              ld_grant;
    grant_t            grant_next;
    logic              we_next;
    logic [ADDR_W-1:0] waddr_next;
    logic [DATA_W-1:0] wdata_next;
    logic              end_next;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (ld_issue),
        .set_addr  (ld_issue_addr),
        .clr_en    (ld_grant),
        .clr_addr  (ld_addr),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .waw_addr  (alu_addr),
        .stall     (stall),
        .waw_busy  (waw_busy),
        .issue_err (ld_issue_err)
    );

    // An ALU write to a register with a load outstanding would be overwritten
    // by the late load data, so it waits until that load has been granted.
    assign alu_elig = alu_valid && !waw_busy;
    assign ld_elig  = ld_valid;

    always_comb begin
        alu_grant  = 1'b0;
        ld_grant   = 1'b0;
        grant_next = last_grant;
        we_next    = 1'b0;
        waddr_next = rf_waddr;
        wdata_next = rf_wdata;
        end_next   = 1'b0;

        if (alu_elig && (!ld_elig || last_grant == GRANT_LD)) begin
            alu_grant  = 1'b1;
            grant_next = GRANT_ALU;
            we_next    = (alu_addr != ZERO);
            waddr_next = alu_addr;
            wdata_next = alu_data;
            end_next   = 1'b1;
        end else if (ld_elig) begin
            ld_grant   = 1'b1;
            grant_next = GRANT_LD;
            we_next    = (ld_addr != ZERO);
            waddr_next = ld_addr;
            wdata_next = ld_data;
            end_next   = 1'b1;
        end
    end

    assign alu_ready = alu_grant;
    assign ld_ready  = ld_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GRANT_LD;
        end else begin
            last_grant <= grant_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            end_instr <= 1'b0;
        end else begin
            rf_we     <= we_next;
            rf_waddr  <= waddr_next;
            rf_wdata  <= wdata_next;
            end_instr <= end_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(alu_ready && ld_ready))
                else $error("both write-back sources granted in one cycle");
            assert (!(rf_we && rf_waddr == ZERO))
                else $error("write presented to register zero");
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus pushes expected write-backs into
// a queue, a negedge monitor pops and compares whenever end_instr is seen.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int W  = 1 + AW + DW;

    logic          clk;
    logic          reset;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          ld_issue;
    logic [AW-1:0] ld_issue_addr;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          end_instr;
    logic          ld_issue_err;
    grant_t        last_grant;

    logic [W-1:0] exp_q[$];
    int errors;
    int checks;

    rf_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .ld_issue      (ld_issue),
        .ld_issue_addr (ld_issue_addr),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .stall         (stall),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .end_instr     (end_instr),
        .ld_issue_err  (ld_issue_err),
        .last_grant    (last_grant)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: one cycle of stimulus, checked at the following negedge.
    task automatic step(
        input logic          av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
        input logic          li, input logic [AW-1:0] lia,
        input logic          lv, input logic [AW-1:0] la, input logic [DW-1:0] ldat,
        input logic [AW-1:0] r1, input logic [AW-1:0] r2,
        input logic          e_ar, input logic e_lr, input logic e_st
    );
        @(posedge clk);
        #1;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_issue = li; ld_issue_addr = lia;
        ld_valid = lv; ld_addr = la; ld_data = ldat;
        rd_addr1 = r1; rd_addr2 = r2;
        @(negedge clk);
        check_val("alu_ready", DW'(alu_ready), DW'(e_ar));
        check_val("ld_ready", DW'(ld_ready), DW'(e_lr));
        check_val("stall", DW'(stall), DW'(e_st));
        if (e_ar) exp_q.push_back({aa != '0, aa, ad});
        if (e_lr) exp_q.push_back({la != '0, la, ldat});
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic e_st);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, r1, '0, 1'b0, 1'b0, e_st);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (end_instr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got we=%0b addr=%0d data=0x%0h expected no write-back",
                             rf_we, rf_waddr, rf_wdata);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (rf_we !== e[W-1] ||
                        (e[W-1] && (rf_waddr !== e[DW+AW-1:DW] || rf_wdata !== e[DW-1:0]))) begin
                        errors++;
                        $display("FAIL wb_write: got we=%0b addr=%0d data=0x%0h expected we=%0b addr=%0d data=0x%0h",
                                 rf_we, rf_waddr, rf_wdata, e[W-1], e[DW+AW-1:DW], e[DW-1:0]);
                    end
                end
            end else begin
                checks++;
                if (rf_we !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_idle_we: got rf_we=%0b expected 0 without end_instr", rf_we);
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_addr = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;

        repeat (2) @(posedge clk);
        #2;
        check_val("reset_rf_we", DW'(rf_we), '0);
        check_val("reset_rf_waddr", DW'(rf_waddr), '0);
        check_val("reset_rf_wdata", rf_wdata, '0);
        check_val("reset_end_instr", DW'(end_instr), '0);
        check_val("reset_err", DW'(ld_issue_err), '0);
        check_val("reset_last_grant", DW'(last_grant), DW'(GRANT_LD));
        @(negedge clk);
        reset = 1'b1;

        // ALU only: first tie-free grant goes straight through
        step(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        // Load only, leaves last_grant = LD
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd4, 32'h44, '0, '0, 1'b0, 1'b1, 1'b0);
        // Round-robin with both sources requesting
        step(1'b1, 5'd1, 32'h11, 1'b0, '0, 1'b1, 5'd2, 32'h22, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 32'h33, 1'b0, '0, 1'b1, 5'd2, 32'h22, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd3, 32'h33, 1'b0, '0, 1'b1, 5'd6, 32'h66, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd6, 32'h66, '0, '0, 1'b0, 1'b1, 1'b0);

        // Read hazard against load to r9
        step(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, '0, '0, 5'd9, '0, 1'b0, 1'b0, 1'b0);
        idle(5'd9, 1'b1);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd9, 32'h1234, 5'd9, '0, 1'b0, 1'b1, 1'b1);
        idle(5'd9, 1'b0);

        // WAW: ALU to r5 blocked until the load to r5 is granted
        step(1'b0, '0, '0, 1'b1, 5'd5, 1'b0, '0, '0, '0, 5'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd5, 32'h55, 1'b0, '0, 1'b0, '0, '0, '0, 5'd5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5'd5, 32'h55, 1'b0, '0, 1'b0, '0, '0, '0, 5'd5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5'd5, 32'h55, 1'b0, '0, 1'b1, 5'd5, 32'h5A, '0, 5'd5, 1'b0, 1'b1, 1'b1);
        step(1'b1, 5'd5, 32'h55, 1'b0, '0, 1'b0, '0, '0, '0, 5'd5, 1'b1, 1'b0, 1'b0);

        // Register zero: handshake completes, no write, never pending
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 5'd0, 1'b0, '0, '0, 5'd0, '0, 1'b0, 1'b0, 1'b0);
        idle(5'd0, 1'b0);
        check_val("err_after_zero_issue", DW'(ld_issue_err), '0);

        // Double issue to r12 sets the sticky error
        step(1'b0, '0, '0, 1'b1, 5'd12, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 5'd12, 1'b0, '0, '0, 5'd12, '0, 1'b0, 1'b0, 1'b1);
        idle(5'd12, 1'b1);
        check_val("err_set", DW'(ld_issue_err), 32'd1);
        idle(5'd12, 1'b1);
        check_val("err_sticky", DW'(ld_issue_err), 32'd1);

        // Reset with a granted write registered but not yet observed
        step(1'b1, 5'd3, 32'hABCD, 1'b0, '0, 1'b0, '0, '0, 5'd12, '0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_val("midreset_rf_we", DW'(rf_we), '0);
        check_val("midreset_end_instr", DW'(end_instr), '0);
        check_val("midreset_err", DW'(ld_issue_err), '0);
        check_val("midreset_stall", DW'(stall), '0);
        @(negedge clk);
        reset = 1'b1;
        idle(5'd12, 1'b0);
        // r12 no longer pending, so an ALU write to it goes through
        step(1'b1, 5'd12, 32'h0C0C, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle('0, 1'b0);
        idle('0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending write-backs expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
